// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache that refills whole lines over a BurstRAM read port.
// Define ICACHE_FLUSH_EN to add a flush input that invalidates every line.
module icache_2way #(
  parameter int ADDRESS_BITWIDTH        = 32,
  parameter int DATA_BITWIDTH           = 32,
  parameter int SET_IX_BITWIDTH         = 1,
  parameter int LINE_IX_BITWIDTH        = 3,
  parameter int RAM_DEPTH_BITWIDTH      = 8,
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
`ifdef ICACHE_FLUSH_EN
  input  logic                                 flush,
`endif
  input  logic [ADDRESS_BITWIDTH-1:0]          addr,
  output logic [DATA_BITWIDTH-1:0]             dout,
  output logic                                 rdy,
  output logic                                 bsy,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
);

  localparam int NSETS           = 1 << SET_IX_BITWIDTH;
  localparam int NWORDS          = 1 << LINE_IX_BITWIDTH;
  localparam int SET_LSB         = LINE_IX_BITWIDTH + 2;
  localparam int TAG_LSB         = SET_LSB + SET_IX_BITWIDTH;
  localparam int TAG_W           = ADDRESS_BITWIDTH - TAG_LSB;
  localparam int WPB             = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
  localparam int BEAT_W          = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
  localparam int BEAT_BYTES_LOG2 = $clog2(RAM_BURST_DATA_BITWIDTH / 8);

  if (RAM_BURST_DATA_COUNT * RAM_BURST_DATA_BITWIDTH != NWORDS * DATA_BITWIDTH) begin : g_line_size_check
    $error("icache_2way: burst size does not match cache line size");
  end

  typedef enum logic [1:0] {IDLE, FILL_CMD, FILL_DATA, RESPOND} state_t;

  state_t                        state_q, state_d;
  logic [ADDRESS_BITWIDTH-1:0]   req_addr_q, req_addr_d;
  logic                          victim_q, victim_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [NSETS-1:0]              val0_q, val0_d, val1_q, val1_d, lru_q, lru_d;
  logic                          rdy_q, rdy_d, bsy_q, bsy_d, br_cmd_en_q, br_cmd_en_d;
  logic [DATA_BITWIDTH-1:0]      dout_q, dout_d;
`ifdef ICACHE_FLUSH_EN
  logic                          flush_pend_q, flush_pend_d;
`endif

  logic [TAG_W-1:0]         tag_mem  [2][NSETS];
  logic [DATA_BITWIDTH-1:0] data_mem [2][NSETS][NWORDS];

  logic [LINE_IX_BITWIDTH-1:0] lk_word, f_word;
  logic [SET_IX_BITWIDTH-1:0]  lk_set, f_set;
  logic [TAG_W-1:0]            lk_tag, f_tag;
  logic                        hit0, hit1, beat_wr, last_beat, req_in_beat;
  logic [ADDRESS_BITWIDTH-1:0] line_base;
  logic                        unused_addr_bits;

  assign lk_word = addr[SET_LSB-1:2];
  assign lk_set  = addr[TAG_LSB-1:SET_LSB];
  assign lk_tag  = addr[ADDRESS_BITWIDTH-1:TAG_LSB];
  assign f_word  = req_addr_q[SET_LSB-1:2];
  assign f_set   = req_addr_q[TAG_LSB-1:SET_LSB];
  assign f_tag   = req_addr_q[ADDRESS_BITWIDTH-1:TAG_LSB];

  assign hit0 = val0_q[lk_set] && (tag_mem[0][lk_set] == lk_tag);
  assign hit1 = val1_q[lk_set] && (tag_mem[1][lk_set] == lk_tag);

  assign beat_wr     = (state_q == FILL_DATA) && br_rd_data_valid;
  assign last_beat   = beat_wr && (beat_q == BEAT_W'(RAM_BURST_DATA_COUNT - 1));
  assign req_in_beat = (int'(f_word) / WPB) == int'(beat_q);

  assign line_base        = {req_addr_q[ADDRESS_BITWIDTH-1:SET_LSB], {SET_LSB{1'b0}}};
  assign unused_addr_bits = ^{addr[1:0], req_addr_q[1:0]};

  assign dout         = dout_q;
  assign rdy          = rdy_q;
  assign bsy          = bsy_q;
  assign br_cmd       = 1'b0;
  assign br_cmd_en    = br_cmd_en_q;
  assign br_addr      = RAM_DEPTH_BITWIDTH'(line_base >> BEAT_BYTES_LOG2);
  assign br_wr_data   = '0;
  assign br_data_mask = '0;

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    victim_d    = victim_q;
    beat_d      = beat_q;
    val0_d      = val0_q;
    val1_d      = val1_q;
    lru_d       = lru_q;
    rdy_d       = 1'b0;
    bsy_d       = bsy_q;
    dout_d      = dout_q;
    br_cmd_en_d = 1'b0;
`ifdef ICACHE_FLUSH_EN
    flush_pend_d = flush_pend_q;
    if (flush && state_q != IDLE) flush_pend_d = 1'b1;
`endif
    unique case (state_q)
      IDLE: begin
        bsy_d = 1'b0;
`ifdef ICACHE_FLUSH_EN
        if (flush || flush_pend_q) begin
          val0_d       = '0;
          val1_d       = '0;
          bsy_d        = 1'b1;
          flush_pend_d = 1'b0;
        end else if (bsy_q) begin
          // cycle following a flush: no lookup, bsy simply drops
        end else
`endif
        if (hit0 || hit1) begin
          rdy_d         = 1'b1;
          dout_d        = hit0 ? data_mem[0][lk_set][lk_word] : data_mem[1][lk_set][lk_word];
          lru_d[lk_set] = hit0;
        end else begin
          req_addr_d = addr;
          victim_d   = !val0_q[lk_set] ? 1'b0 : (!val1_q[lk_set] ? 1'b1 : lru_q[lk_set]);
          state_d    = FILL_CMD;
          bsy_d      = 1'b1;
        end
      end
      FILL_CMD: begin
        if (!br_busy) begin
          br_cmd_en_d = 1'b1;
          state_d     = FILL_DATA;
        end
      end
      FILL_DATA: begin
        if (beat_wr) begin
          beat_d = beat_q + BEAT_W'(1);
          if (last_beat) begin
            beat_d = '0;
            if (victim_q) val1_d[f_set] = 1'b1;
            else          val0_d[f_set] = 1'b1;
            lru_d[f_set] = ~victim_q;
            state_d      = RESPOND;
            rdy_d        = 1'b1;
            // the requested word may be arriving in this very beat, before it reaches the array
            dout_d = req_in_beat
                   ? br_rd_data[(int'(f_word) % WPB) * DATA_BITWIDTH +: DATA_BITWIDTH]
                   : data_mem[victim_q][f_set][f_word];
          end
        end
      end
      RESPOND: begin
        state_d = IDLE;
        bsy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      victim_q    <= 1'b0;
      beat_q      <= '0;
      val0_q      <= '0;
      val1_q      <= '0;
      lru_q       <= '0;
      rdy_q       <= 1'b0;
      bsy_q       <= 1'b0;
      dout_q      <= '0;
      br_cmd_en_q <= 1'b0;
`ifdef ICACHE_FLUSH_EN
      flush_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      victim_q    <= victim_d;
      beat_q      <= beat_d;
      val0_q      <= val0_d;
      val1_q      <= val1_d;
      lru_q       <= lru_d;
      rdy_q       <= rdy_d;
      bsy_q       <= bsy_d;
      dout_q      <= dout_d;
      br_cmd_en_q <= br_cmd_en_d;
`ifdef ICACHE_FLUSH_EN
      flush_pend_q <= flush_pend_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (beat_wr) begin
      for (int unsigned i = 0; i < WPB; i++) begin
        data_mem[victim_q][f_set][LINE_IX_BITWIDTH'(int'(beat_q) * WPB + i)]
          <= br_rd_data[i * DATA_BITWIDTH +: DATA_BITWIDTH];
      end
    end
    if (last_beat) tag_mem[victim_q][f_set] <= f_tag;
  end

endmodule

// File: tb/tb_icache_2way.sv
// Randomized bench for icache_2way: BurstRAM responder plus a recency-ordered per-set line model.
module tb_icache_2way;

  logic        clk, rst;
  logic [31:0] addr;
  logic [31:0] dout;
  logic        rdy, bsy, br_cmd, br_cmd_en;
  logic [7:0]  br_addr;
  logic [63:0] br_wr_data, br_rd_data;
  logic [7:0]  br_data_mask;
  logic        br_rd_data_valid, br_busy;
`ifdef ICACHE_FLUSH_EN
  logic        flush;
`endif

  icache_2way #(
    .ADDRESS_BITWIDTH(32), .DATA_BITWIDTH(32), .SET_IX_BITWIDTH(1), .LINE_IX_BITWIDTH(3),
    .RAM_DEPTH_BITWIDTH(8), .RAM_BURST_DATA_COUNT(4), .RAM_BURST_DATA_BITWIDTH(64)
  ) dut (
    .clk(clk), .rst(rst),
`ifdef ICACHE_FLUSH_EN
    .flush(flush),
`endif
    .addr(addr), .dout(dout), .rdy(rdy), .bsy(bsy),
    .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr), .br_wr_data(br_wr_data),
    .br_data_mask(br_data_mask), .br_rd_data(br_rd_data),
    .br_rd_data_valid(br_rd_data_valid), .br_busy(br_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [63:0] ram [256];
  logic [7:0]  pend [$];
  logic [7:0]  last_br_addr;
  int          cmd_cnt = 0, beat_cnt = 0;
  bit          hold_busy = 1'b0;
  int          n_checks = 0, n_pass = 0;

  // model: per set, most-recently-used tag and the other resident tag
  logic [25:0] mru [2], oth [2];
  int          cnt [2];

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] exp_braddr(input logic [31:0] a);
    return 8'((a & ~32'h1F) >> 3);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [7:0] b;
    b = exp_braddr(a) + 8'(a[4:3]);
    return a[2] ? ram[b][63:32] : ram[b][31:0];
  endfunction

  task automatic model_clear();
    cnt[0] = 0;
    cnt[1] = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (br_cmd_en) begin
        cmd_cnt++;
        last_br_addr = br_addr;
        pend.push_back(br_addr);
      end
    end
  end

  task automatic next_neg();
    @(negedge clk);
    br_busy = hold_busy || ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    logic [7:0] b;
    br_rd_data_valid = 1'b0;
    br_rd_data       = '0;
    br_busy          = 1'b0;
    forever begin
      next_neg();
      br_rd_data_valid = 1'b0;
      if (pend.size() != 0) begin
        b = pend.pop_front();
        for (int unsigned k = 0; k < 4; k++) begin
          repeat ($urandom_range(0, 2)) next_neg();
          br_rd_data       = ram[b + 8'(k)];
          br_rd_data_valid = 1'b1;
          beat_cnt++;
          next_neg();
          br_rd_data_valid = 1'b0;
        end
      end else if (!br_cmd_en && $urandom_range(0, 7) == 0) begin
        br_rd_data       = {$urandom, $urandom};
        br_rd_data_valid = 1'b1;
      end
    end
  end

  // called at posedge+1; the DUT looks up addr at the following edge
  task automatic access(input logic [31:0] a);
    logic [25:0] t;
    logic [31:0] ew;
    int          s, c0, n;
    bit          hit;
    t   = a[31:6];
    s   = int'(a[5]);
    ew  = exp_word(a);
    hit = (cnt[s] > 0 && mru[s] == t) || (cnt[s] > 1 && oth[s] == t);
    c0  = cmd_cnt;
    addr = a;
    @(posedge clk); #1;
    if (hit) begin
      check_eq("hit", 96'({rdy, bsy, dout}), 96'({1'b1, 1'b0, ew}));
      check_eq("hit_nocmd", 96'(cmd_cnt - c0), 96'd0);
      if (mru[s] != t) begin
        oth[s] = mru[s];
        mru[s] = t;
      end
    end else begin
      check_eq("miss_start", 96'({rdy, bsy}), 96'(2'b01));
      addr = $urandom;
      n = 0;
      while (!rdy && n < 80) begin
        @(posedge clk); #1;
        n++;
      end
      check_eq("fill_done", 96'(rdy), 96'd1);
      check_eq("fill_word", 96'({bsy, dout}), 96'({1'b1, ew}));
      check_eq("fill_cmds", 96'(cmd_cnt - c0), 96'd1);
      check_eq("fill_braddr", 96'(last_br_addr), 96'(exp_braddr(a)));
      if (cnt[s] > 0) oth[s] = mru[s];
      mru[s] = t;
      if (cnt[s] < 2) cnt[s]++;
      @(posedge clk); #1;
      check_eq("fill_release", 96'({rdy, bsy}), 96'(2'b00));
    end
  endtask

  task automatic reset_mid_fill(input logic [31:0] a);
    int b0, n;
    b0 = beat_cnt;
    addr = a;
    n = 0;
    while (beat_cnt < b0 + 2 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_reached", 96'(beat_cnt >= b0 + 2), 96'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_outs", 96'({rdy, bsy, br_cmd_en, dout}), 96'd0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    hold_busy = 1'b1;
    fork
      begin
        repeat (8) @(negedge clk);
        hold_busy = 1'b0;
      end
    join_none
    access(a);
  endtask

`ifdef ICACHE_FLUSH_EN
  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_hold", 96'({rdy, bsy}), 96'(2'b01));
    model_clear();
    @(posedge clk); #1;
    check_eq("flush_release", 96'({rdy, bsy}), 96'(2'b00));
  endtask
`endif

  initial begin
    logic [31:0] a;
    rst  = 1'b1;
    addr = '0;
`ifdef ICACHE_FLUSH_EN
    flush = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ram[i] = {$urandom, $urandom};
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outs", 96'({rdy, bsy, br_cmd_en, dout}), 96'd0);
    check_eq("rst_cmd_mask", 96'({br_cmd, br_data_mask}), 96'd0);
    check_eq("rst_wr_data", 96'(br_wr_data), 96'd0);
    rst = 1'b0;

    access(32'h00);
    check_eq("s1_braddr", 96'(last_br_addr), 96'd0);
    access(32'h04);
    access(32'h08);
    access(32'h40);
    access(32'h00);
    access(32'h80);
    access(32'h00);
    access(32'h40);
    reset_mid_fill(32'h20);
    check_eq("s5_braddr", 96'(last_br_addr), 96'd4);
    access(32'h20);

`ifdef ICACHE_FLUSH_EN
    access(32'h00);
    access(32'h04);
    flush_pulse();
    access(32'h00);
`endif

    repeat (300) begin
      a = {26'($urandom_range(0, 5)), 1'($urandom), 3'($urandom), 2'b00};
      if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
      access(a);
    end
    check_eq("final_ctrl", 96'({br_cmd, br_data_mask}), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
